// File: rtl/control_sequencer.sv
// control_sequencer: T-state ring counter and opcode decoder for the 8-bit
// bus-based microprocessor. It drives the per-cycle control word for the
// PC, MAR, ROM, IR, accumulator, B register, ALU and output register.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset; also blanks the control word
//   opcode[3:0]  IR[7:4]; decoded in T4..T6
//   sig[6:0]     inc, PC_LD, PC_OE, MAR_LD, ROM_OE, IR_LD, IR_OE  (bit 0..6)
//   ext[5:0]     A_LD, A_OE, SU, ALU_OE, B_LD, OUT_LD             (bit 0..5)
//   tstate[5:0]  one-hot T-state, bit 0 = T1
//   halted       set when HLT executes, cleared only by clr
//   instr_count  retired-instruction counter, wraps
//
// Parameters:
//   FAST_NOP  nonzero: skip T-states with an all-zero control word
//   CNT_W     width of instr_count
module control_sequencer #(
  parameter int unsigned FAST_NOP = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       opcode,
  output logic [6:0]       sig,
  output logic [5:0]       ext,
  output logic [5:0]       tstate,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TW = 6;

  localparam logic [TW-1:0] T1 = 6'b000001;
  localparam logic [TW-1:0] T2 = 6'b000010;
  localparam logic [TW-1:0] T3 = 6'b000100;
  localparam logic [TW-1:0] T4 = 6'b001000;
  localparam logic [TW-1:0] T5 = 6'b010000;
  localparam logic [TW-1:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // sig bit positions
  localparam int unsigned S_INC    = 0;
  localparam int unsigned S_PC_LD  = 1;
  localparam int unsigned S_PC_OE  = 2;
  localparam int unsigned S_MAR_LD = 3;
  localparam int unsigned S_ROM_OE = 4;
  localparam int unsigned S_IR_LD  = 5;
  localparam int unsigned S_IR_OE  = 6;

  // ext bit positions
  localparam int unsigned E_A_LD   = 0;
  localparam int unsigned E_A_OE   = 1;
  localparam int unsigned E_SU     = 2;
  localparam int unsigned E_ALU_OE = 3;
  localparam int unsigned E_B_LD   = 4;
  localparam int unsigned E_OUT_LD = 5;

  logic [TW-1:0]    tstate_q, tstate_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic op_nop;
  logic fast_last;
  logic end_instr;

  assign op_nop = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT});

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Last active T-state of the current opcode. The NOP shortcut at T3 relies
  // on the opcode already being presented during T3.
  always_comb begin
    fast_last = 1'b0;
    case (tstate_q)
      T3:      fast_last = op_nop;
      T4:      fast_last = (opcode == OP_JMP) || (opcode == OP_OUT);
      T5:      fast_last = (opcode == OP_LDA);
      T6:      fast_last = 1'b1;
      default: fast_last = 1'b0;
    endcase
  end

  assign end_instr = (tstate_q == T6) || ((FAST_NOP != 0) && fast_last);

  // Next state: ring advance, early return to T1, HLT freeze, retire count
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    count_d  = count_q;
    if (!halted_q) begin
      if ((tstate_q == T4) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
        count_d  = count_q + CNT_W'(1);
      end else if (end_instr) begin
        tstate_d = T1;
        count_d  = count_q + CNT_W'(1);
      end else begin
        case (tstate_q)
          T1, T2, T3, T4, T5: tstate_d = {tstate_q[TW-2:0], 1'b0};
          default:            tstate_d = T1;
        endcase
      end
    end
  end

  // Control word decode; blanked during reset and after halt
  always_comb begin
    sig = '0;
    ext = '0;
    if (!clr && !halted_q) begin
      case (tstate_q)
        T1: begin
          sig[S_PC_OE]  = 1'b1;
          sig[S_MAR_LD] = 1'b1;
        end
        T2: sig[S_INC] = 1'b1;
        T3: begin
          sig[S_ROM_OE] = 1'b1;
          sig[S_IR_LD]  = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              sig[S_IR_OE]  = 1'b1;
              sig[S_MAR_LD] = 1'b1;
            end
            OP_JMP: begin
              sig[S_IR_OE] = 1'b1;
              sig[S_PC_LD] = 1'b1;
            end
            OP_OUT: begin
              ext[E_A_OE]   = 1'b1;
              ext[E_OUT_LD] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              sig[S_ROM_OE] = 1'b1;
              ext[E_A_LD]   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              sig[S_ROM_OE] = 1'b1;
              ext[E_B_LD]   = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            ext[E_ALU_OE] = 1'b1;
            ext[E_A_LD]   = 1'b1;
          end
          if (opcode == OP_SUB) ext[E_SU] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tstate      = tstate_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. dut0 runs with FAST_NOP=0 and dut1
// with FAST_NOP=1; both share clk/clr/opcode and 'sel' picks which one is
// checked. Each step pushes its expected outputs onto a scoreboard queue and
// pops/compares them mid-cycle.
module tb_control_sequencer;

  typedef struct {
    string      tag;
    logic [5:0] t;
    logic [6:0] s;
    logic [5:0] e;
    logic       h;
    logic [7:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;
  logic       sel;

  logic [6:0] sig0, sig1;
  logic [5:0] ext0, ext1;
  logic [5:0] ts0, ts1;
  logic       h0, h1;
  logic [7:0] cnt0, cnt1;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  control_sequencer #(.FAST_NOP(0), .CNT_W(8)) dut0 (
    .clk(clk), .clr(clr), .opcode(opcode), .sig(sig0), .ext(ext0),
    .tstate(ts0), .halted(h0), .instr_count(cnt0)
  );

  control_sequencer #(.FAST_NOP(1), .CNT_W(8)) dut1 (
    .clk(clk), .clr(clr), .opcode(opcode), .sig(sig1), .ext(ext1),
    .tstate(ts1), .halted(h1), .instr_count(cnt1)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t       x;
    logic [6:0] s;
    logic [5:0] e;
    logic [5:0] t;
    logic       h;
    logic [7:0] c;
    logic [4:0] drv;
    x = sb.pop_front();
    s = sel ? sig1 : sig0;
    e = sel ? ext1 : ext0;
    t = sel ? ts1  : ts0;
    h = sel ? h1   : h0;
    c = sel ? cnt1 : cnt0;
    cmp({x.tag, ".tstate"}, 32'(t), 32'(x.t));
    cmp({x.tag, ".sig"},    32'(s), 32'(x.s));
    cmp({x.tag, ".ext"},    32'(e), 32'(x.e));
    cmp({x.tag, ".halted"}, 32'(h), 32'(x.h));
    cmp({x.tag, ".count"},  32'(c), 32'(x.c));
    // PC_OE, ROM_OE, IR_OE, A_OE, ALU_OE
    drv = {s[2], s[4], s[6], e[1], e[3]};
    cmp({x.tag, ".bus_excl"}, 32'($countones(drv) <= 1), 32'd1);
  endtask

  // One clock cycle: drive inputs, record expectation, check at negedge.
  task automatic cyc(input string tag, input logic clr_v, input logic [3:0] op_v,
                     input logic [5:0] t, input logic [6:0] s, input logic [5:0] e,
                     input logic h, input logic [7:0] c);
    exp_t x;
    clr    = clr_v;
    opcode = op_v;
    x.tag = tag; x.t = t; x.s = s; x.e = e; x.h = h; x.c = c;
    sb.push_back(x);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr    = 1'b1;
    opcode = 4'b0000;
    sel    = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles
    cyc("rst0", 1, 4'h0, 6'b000001, 7'b0000000, 6'b000000, 0, 8'd0);
    cyc("rst1", 1, 4'h0, 6'b000001, 7'b0000000, 6'b000000, 0, 8'd0);

    // ADD, six cycles
    cyc("add_t1", 0, 4'h1, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd0);
    cyc("add_t2", 0, 4'h1, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd0);
    cyc("add_t3", 0, 4'h1, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd0);
    cyc("add_t4", 0, 4'h1, 6'b001000, 7'b1001000, 6'b000000, 0, 8'd0);
    cyc("add_t5", 0, 4'h1, 6'b010000, 7'b0010000, 6'b010000, 0, 8'd0);
    cyc("add_t6", 0, 4'h1, 6'b100000, 7'b0000000, 6'b001001, 0, 8'd0);

    // SUB; opcode garbage during fetch must not matter
    cyc("sub_t1", 0, 4'h5, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd1);
    cyc("sub_t2", 0, 4'hF, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd1);
    cyc("sub_t3", 0, 4'hE, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd1);
    cyc("sub_t4", 0, 4'h2, 6'b001000, 7'b1001000, 6'b000000, 0, 8'd1);
    cyc("sub_t5", 0, 4'h2, 6'b010000, 7'b0010000, 6'b010000, 0, 8'd1);
    cyc("sub_t6", 0, 4'h2, 6'b100000, 7'b0000000, 6'b001101, 0, 8'd1);

    // OUT
    cyc("out_t1", 0, 4'hE, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd2);
    cyc("out_t2", 0, 4'hE, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd2);
    cyc("out_t3", 0, 4'hE, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd2);
    cyc("out_t4", 0, 4'hE, 6'b001000, 7'b0000000, 6'b100010, 0, 8'd2);
    cyc("out_t5", 0, 4'hE, 6'b010000, 7'b0000000, 6'b000000, 0, 8'd2);
    cyc("out_t6", 0, 4'hE, 6'b100000, 7'b0000000, 6'b000000, 0, 8'd2);

    // HLT: freezes in T4, counts once
    cyc("hlt_t1", 0, 4'hF, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd3);
    cyc("hlt_t2", 0, 4'hF, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd3);
    cyc("hlt_t3", 0, 4'hF, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd3);
    cyc("hlt_t4", 0, 4'hF, 6'b001000, 7'b0000000, 6'b000000, 0, 8'd3);
    for (int i = 0; i < 21; i++) begin
      cyc("hlt_hold", 0, 4'(i), 6'b001000, 7'b0000000, 6'b000000, 1, 8'd4);
    end
    cyc("hlt_clr", 1, 4'h1, 6'b001000, 7'b0000000, 6'b000000, 1, 8'd4);

    // ADD aborted by reset during T5
    cyc("ab_t1", 0, 4'h1, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd0);
    cyc("ab_t2", 0, 4'h1, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd0);
    cyc("ab_t3", 0, 4'h1, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd0);
    cyc("ab_t4", 0, 4'h1, 6'b001000, 7'b1001000, 6'b000000, 0, 8'd0);
    cyc("ab_t5", 1, 4'h1, 6'b010000, 7'b0000000, 6'b000000, 0, 8'd0);
    cyc("ab_rel", 0, 4'h1, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd0);
    cyc("ab_rst", 1, 4'h1, 6'b000010, 7'b0000000, 6'b000000, 0, 8'd0);

    // FAST_NOP instance: JMP, LDA, NOP
    sel = 1'b1;
    cyc("f_rst",   1, 4'h3, 6'b000001, 7'b0000000, 6'b000000, 0, 8'd0);
    cyc("jmp_t1",  0, 4'h3, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd0);
    cyc("jmp_t2",  0, 4'h3, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd0);
    cyc("jmp_t3",  0, 4'h3, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd0);
    cyc("jmp_t4",  0, 4'h3, 6'b001000, 7'b1000010, 6'b000000, 0, 8'd0);
    cyc("lda_t1",  0, 4'h0, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd1);
    cyc("lda_t2",  0, 4'h0, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd1);
    cyc("lda_t3",  0, 4'h0, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd1);
    cyc("lda_t4",  0, 4'h0, 6'b001000, 7'b1001000, 6'b000000, 0, 8'd1);
    cyc("lda_t5",  0, 4'h0, 6'b010000, 7'b0010000, 6'b000001, 0, 8'd1);
    cyc("nop_t1",  0, 4'h5, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd2);
    cyc("nop_t2",  0, 4'h5, 6'b000010, 7'b0000001, 6'b000000, 0, 8'd2);
    cyc("nop_t3",  0, 4'h5, 6'b000100, 7'b0110000, 6'b000000, 0, 8'd2);
    cyc("f_end",   0, 4'h1, 6'b000001, 7'b0001100, 6'b000000, 0, 8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
